// File: rtl/servo_pkg.sv
// Shared constants, types and the mode decode helper for the servo PWM bank.
package servo_pkg;

    localparam int NUM_CH            = 7;
    localparam int DEG_W             = 6;
    localparam int MODE_W            = 3;
    localparam int DEFAULT_RESET_POS = 6;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } ch_sel_t;

    // Mode k addresses channel k-1; mode 0 addresses nothing.
    function automatic ch_sel_t mode_to_ch(input logic [MODE_W-1:0] mode);
        ch_sel_t sel;
        sel.valid = (mode != '0);
        sel.idx   = mode - 3'd1;
        return sel;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and PWM unit counter shared by all servo channels; flags the
// frame boundary edge and exposes the unit count of the next cycle.
module pwm_timebase #(
    parameter  int TICK_DIV     = 1000,
    parameter  int PERIOD_UNITS = 1280,
    localparam int PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
    localparam int UW           = $clog2(PERIOD_UNITS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_tick,
    output logic          o_boundary,
    output logic [UW-1:0] o_unit,
    output logic [UW-1:0] o_unit_next
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [UW-1:0] UNIT_LAST  = UW'(PERIOD_UNITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [UW-1:0] unit_q, unit_d;

    always_comb begin
        o_tick     = (presc_q == PRESC_LAST);
        o_boundary = o_tick && (unit_q == UNIT_LAST);
        presc_d    = o_tick ? '0 : presc_q + 1'b1;
        unit_d     = unit_q;
        if (o_tick) begin
            unit_d = (unit_q == UNIT_LAST) ? '0 : unit_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
            unit_q  <= '0;
        end else begin
            presc_q <= presc_d;
            unit_q  <= unit_d;
        end
    end

    assign o_unit      = unit_q;
    assign o_unit_next = unit_d;

endmodule

// File: rtl/servo_pwm_bank.sv
// Seven-channel servo PWM bank: captures mode/degree commands into a pending
// buffer and applies them only at frame boundaries so pulses never glitch.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int PERIOD_UNITS = 1280,
    parameter int BASE_UNITS   = 64,
    parameter int RESET_POS    = DEFAULT_RESET_POS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [DEG_W-1:0]  i_deg,
    input  logic              i_newtask,
    output logic [NUM_CH-1:0] o_pwm,
    output logic              o_frame,
    output logic [NUM_CH-1:0] o_applied,
    output logic              o_busy
);

    localparam int UW     = $clog2(PERIOD_UNITS);
    localparam int BW     = $clog2(BASE_UNITS + 64);
    localparam int SW     = ((UW > BW) ? UW : BW) + 1;

    if (TICK_DIV < 1) begin : g_tick_check
        $error("servo_pwm_bank: TICK_DIV must be at least 1");
    end
    if (BASE_UNITS + 63 >= PERIOD_UNITS) begin : g_period_check
        $error("servo_pwm_bank: BASE_UNITS + 63 must be below PERIOD_UNITS");
    end

    logic          tick;
    logic          boundary;
    logic [UW-1:0] unit;
    logic [UW-1:0] unit_next;

    pwm_timebase #(
        .TICK_DIV    (TICK_DIV),
        .PERIOD_UNITS(PERIOD_UNITS)
    ) u_timebase (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_tick     (tick),
        .o_boundary (boundary),
        .o_unit     (unit),
        .o_unit_next(unit_next)
    );

    logic [NUM_CH-1:0][DEG_W-1:0] active_q, active_d;
    logic [NUM_CH-1:0][DEG_W-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]            pvalid_q, pvalid_d;
    logic [NUM_CH-1:0]            pwm_q, pwm_d;
    logic [NUM_CH-1:0]            applied_q, applied_d;
    logic                         frame_q, frame_d;
    ch_sel_t                      sel;

    // Apply happens before capture so a strobe on the boundary edge lands in
    // pend for the following frame while any older pending value goes live.
    always_comb begin
        sel       = mode_to_ch(i_mode);
        active_d  = active_q;
        pend_d    = pend_q;
        pvalid_d  = pvalid_q;
        applied_d = '0;
        pwm_d     = '0;
        frame_d   = boundary;
        for (int k = 0; k < NUM_CH; k++) begin
            if (boundary && pvalid_q[k]) begin
                active_d[k]  = pend_q[k];
                pvalid_d[k]  = 1'b0;
                applied_d[k] = 1'b1;
            end
            if (i_newtask && sel.valid && (sel.idx == 3'(k))) begin
                pend_d[k]   = i_deg;
                pvalid_d[k] = 1'b1;
            end
            pwm_d[k] = SW'(unit_next) < (SW'(BASE_UNITS) + SW'(active_d[k]));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active_q  <= {NUM_CH{DEG_W'(RESET_POS)}};
            pend_q    <= '0;
            pvalid_q  <= '0;
            pwm_q     <= '0;
            applied_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            active_q  <= active_d;
            pend_q    <= pend_d;
            pvalid_q  <= pvalid_d;
            pwm_q     <= pwm_d;
            applied_q <= applied_d;
            frame_q   <= frame_d;
        end
    end

    assign o_pwm     = pwm_q;
    assign o_frame   = frame_q;
    assign o_applied = applied_q;
    assign o_busy    = |pvalid_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: frame-position reference model
// checked every cycle, plus directed vectors for widths and apply masks.
module tb_servo_pwm_bank;

    localparam int TD    = 2;
    localparam int PU    = 80;
    localparam int BU    = 8;
    localparam int RP    = 6;
    localparam int FRAME = TD * PU;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [2:0] mode    = '0;
    logic [5:0] deg     = '0;
    logic       newtask = 1'b0;
    logic [6:0] pwm;
    logic [6:0] applied;
    logic       frame;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    servo_pwm_bank #(
        .TICK_DIV    (TD),
        .PERIOD_UNITS(PU),
        .BASE_UNITS  (BU),
        .RESET_POS   (RP)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_mode   (mode),
        .i_deg    (deg),
        .i_newtask(newtask),
        .o_pwm    (pwm),
        .o_frame  (frame),
        .o_applied(applied),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: cycle index since reset, frame position = index mod FRAME.
    int         mC     = 0;
    bit         mValid = 1'b0;
    int         mActive[7];
    int         mPend[7];
    bit         mPv[7];
    logic [6:0] ePwm     = '0;
    logic [6:0] eApplied = '0;
    logic       eFrame   = 1'b0;
    logic       eBusy    = 1'b0;

    task automatic modelEdge();
        int         pos;
        logic [6:0] mask;
        if (rst) begin
            mValid = 1'b1;
            mC     = 0;
            for (int k = 0; k < 7; k++) begin
                mActive[k] = RP;
                mPend[k]   = 0;
                mPv[k]     = 1'b0;
            end
            ePwm     = '0;
            eFrame   = 1'b0;
            eApplied = '0;
        end else if (mValid) begin
            pos  = mC % FRAME;
            mask = '0;
            if (pos == FRAME - 1) begin
                for (int k = 0; k < 7; k++) begin
                    if (mPv[k]) begin
                        mActive[k] = mPend[k];
                        mPv[k]     = 1'b0;
                        mask[k]    = 1'b1;
                    end
                end
            end
            if (newtask && mode != 3'd0) begin
                mPend[int'(mode) - 1] = int'(deg);
                mPv[int'(mode) - 1]   = 1'b1;
            end
            mC++;
            for (int k = 0; k < 7; k++) begin
                ePwm[k] = ((mC % FRAME) < (BU + mActive[k]) * TD);
            end
            eFrame   = (pos == FRAME - 1);
            eApplied = mask;
        end
        eBusy = 1'b0;
        for (int k = 0; k < 7; k++) eBusy |= mPv[k];
    endtask

    initial forever begin
        @(posedge clk);
        modelEdge();
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (mValid) begin
            checkOutput("cycle", {pwm, frame, applied, busy}, {ePwm, eFrame, eApplied, eBusy});
        end
    end

    // All tasks below start and end at a negedge.
    task automatic applyStimulus(input logic [2:0] m, input logic [5:0] d);
        mode    = m;
        deg     = d;
        newtask = 1'b1;
        @(negedge clk);
        newtask = 1'b0;
        mode    = '0;
        deg     = '0;
    endtask

    task automatic waitPos(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (mC % FRAME == p) return;
            @(negedge clk);
        end
        checkOutput("pos_timeout", 16'd0, 16'd1);
    endtask

    task automatic waitFrame();
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            if (frame === 1'b1) return;
            @(negedge clk);
        end
        checkOutput("frame_timeout", 16'd0, 16'd1);
    endtask

    task automatic measureWidth(input int ch, input int expWidth, input string name);
        int cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (pwm[ch] === 1'b1) cnt++;
            @(negedge clk);
        end
        checkOutput(name, 16'(cnt), 16'(expWidth));
    endtask

    typedef struct {
        bit         strobe;
        logic [2:0] mode;
        logic [5:0] deg;
        int         pos;
        logic [6:0] expApplied;
        int         ch;
        int         expWidth;
        string      name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 3'd0, 6'd0,  20,  7'b0000000, 0, 28, "idle_ch0"};
        vecs[1] = '{1'b0, 3'd0, 6'd0,  20,  7'b0000000, 6, 28, "idle_ch6"};
        vecs[2] = '{1'b1, 3'd3, 6'd20, 50,  7'b0000100, 2, 56, "mode3_deg20"};
        vecs[3] = '{1'b1, 3'd0, 6'd50, 40,  7'b0000000, 0, 28, "mode0_dropped"};
        vecs[4] = '{1'b1, 3'd2, 6'd33, 100, 7'b0000010, 1, 82, "mode2_deg33"};
        vecs[5] = '{1'b1, 3'd3, 6'd0,  10,  7'b0000100, 2, 16, "mode3_deg0"};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            waitPos(vecs[i].pos);
            if (vecs[i].strobe) applyStimulus(vecs[i].mode, vecs[i].deg);
            else @(negedge clk);
            checkOutput({vecs[i].name, "_busy"}, 16'(busy),
                        16'(vecs[i].strobe && vecs[i].mode != 3'd0));
            waitFrame();
            checkOutput({vecs[i].name, "_applied"}, 16'(applied), 16'(vecs[i].expApplied));
            measureWidth(vecs[i].ch, vecs[i].expWidth, {vecs[i].name, "_width"});
        end

        // Two commands to channel 0 in one frame: last one wins.
        waitPos(30);
        applyStimulus(3'd1, 6'd10);
        waitPos(60);
        applyStimulus(3'd1, 6'd40);
        waitFrame();
        checkOutput("twice_applied", 16'(applied), 16'h0001);
        measureWidth(0, 96, "twice_width");
        checkOutput("twice_applied_once", 16'(applied), 16'h0000);

        // Strobe exactly on the boundary edge: deferred by one frame.
        waitPos(FRAME - 1);
        applyStimulus(3'd7, 6'd63);
        checkOutput("edge_frame", 16'(frame), 16'd1);
        checkOutput("edge_applied_now", 16'(applied), 16'h0000);
        measureWidth(6, 28, "edge_width_now");
        checkOutput("edge_applied_next", 16'(applied), 16'h0040);
        measureWidth(6, 142, "edge_width_next");

        // Reset mid-frame discards a pending command.
        waitPos(40);
        applyStimulus(3'd5, 6'd30);
        checkOutput("rst_busy_before", 16'(busy), 16'd1);
        waitPos(90);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy_after", 16'(busy), 16'd0);
        waitFrame();
        checkOutput("rst_applied", 16'(applied), 16'h0000);
        measureWidth(4, 28, "rst_width_ch4");
        checkOutput("rst_applied_next", 16'(applied), 16'h0000);
        measureWidth(6, 28, "rst_width_ch6");

        // Random command traffic against the model.
        for (int i = 0; i < 5 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                mode    = 3'($urandom_range(0, 7));
                deg     = 6'($urandom_range(0, 63));
                newtask = 1'b1;
            end else begin
                newtask = 1'b0;
            end
            @(negedge clk);
        end
        newtask = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
